// File: rtl/alu_seq.sv
// alu_seq: registered CR16-style ALU with a persistent CLFZN flag register and an
// iterative one-bit-per-cycle shifter behind a valid/ready handshake.
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [3:0]         opext,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    output logic [WIDTH-1:0]   S,
    output logic [4:0]         CLFZN
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [3:0] K_UNDEF = 4'd0;
    localparam logic [3:0] K_ADDS  = 4'd1;
    localparam logic [3:0] K_ADDU  = 4'd2;
    localparam logic [3:0] K_SUB   = 4'd3;
    localparam logic [3:0] K_CMP   = 4'd4;
    localparam logic [3:0] K_AND   = 4'd5;
    localparam logic [3:0] K_OR    = 4'd6;
    localparam logic [3:0] K_XOR   = 4'd7;
    localparam logic [3:0] K_NOT   = 4'd8;
    localparam logic [3:0] K_MOV   = 4'd9;
    localparam logic [3:0] K_SHIFT = 4'd10;

    localparam logic [1:0] SH_LSH  = 2'd0;
    localparam logic [1:0] SH_ALSH = 2'd1;
    localparam logic [1:0] SH_RSH  = 2'd2;
    localparam logic [1:0] SH_ARSH = 2'd3;

    localparam int FC = 4;
    localparam int FL = 3;
    localparam int FF = 2;
    localparam int FZ = 1;
    localparam int FN = 0;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

    logic [0:0]         state_q;
    logic [WIDTH-1:0]   s_q;
    logic [4:0]         flags_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [1:0]         sh_kind_q;
    logic               msb_chg_q;

    logic [3:0]         kind;
    logic               use_carry;
    logic [1:0]         sh_kind;
    logic               carry_in;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic               add_ovf;
    logic               sub_ovf;
    logic               lt_signed;
    logic [SHAMT_W-1:0] sh_amt;
    logic [WIDTH-1:0]   a_shift1;
    logic               a_msb_chg;
    logic [WIDTH-1:0]   work_shift1;
    logic               work_msb_chg;
    logic [WIDTH-1:0]   res;
    logic [4:0]         flags_n;

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                   input logic [1:0] k);
        logic [WIDTH-1:0] r;
        case (k)
            SH_RSH:  r = {1'b0, v[WIDTH-1:1]};
            SH_ARSH: r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = {v[WIDTH-2:0], 1'b0};
        endcase
        return r;
    endfunction

    // Register-form ops live under opcode 0000 and 1010; every other opcode is an immediate form.
    always_comb begin
        kind      = K_UNDEF;
        use_carry = 1'b0;
        sh_kind   = SH_LSH;
        case (opcode)
            4'b0000: begin
                case (opext)
                    4'b0101: kind = K_ADDS;
                    4'b0110: kind = K_ADDU;
                    4'b0111: begin kind = K_ADDS; use_carry = 1'b1; end
                    4'b1001: kind = K_SUB;
                    4'b1011: kind = K_CMP;
                    4'b0001: kind = K_AND;
                    4'b0010: kind = K_OR;
                    4'b0011: kind = K_XOR;
                    4'b1110: begin kind = K_SHIFT; sh_kind = SH_RSH; end
                    4'b1101: kind = K_MOV;
                    default: kind = K_UNDEF;
                endcase
            end
            4'b0101: kind = K_ADDS;
            4'b0110: kind = K_ADDU;
            4'b0111: begin kind = K_ADDS; use_carry = 1'b1; end
            4'b1001: kind = K_SUB;
            4'b1011: kind = K_CMP;
            4'b1000: begin kind = K_SHIFT; sh_kind = SH_LSH; end
            4'b1110: begin kind = K_SHIFT; sh_kind = SH_RSH; end
            4'b1101: kind = K_MOV;
            4'b1010: begin
                case (opext)
                    4'b0101: begin kind = K_ADDU; use_carry = 1'b1; end
                    4'b0110: begin kind = K_ADDU; use_carry = 1'b1; end
                    4'b0010: kind = K_CMP;
                    4'b0011: kind = K_NOT;
                    4'b0001: begin kind = K_SHIFT; sh_kind = SH_ALSH; end
                    4'b0100: begin kind = K_SHIFT; sh_kind = SH_ARSH; end
                    default: kind = K_UNDEF;
                endcase
            end
            default: kind = K_UNDEF;
        endcase
    end

    assign carry_in  = use_carry & flags_q[FC];
    assign add_sum   = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, carry_in};
    assign sub_diff  = {1'b0, A} - {1'b0, B};
    assign add_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_diff[WIDTH-1] != A[WIDTH-1]);
    assign lt_signed = $signed(A) < $signed(B);

    assign sh_amt       = B[SHAMT_W-1:0];
    assign a_shift1     = shift_one(A, sh_kind);
    assign a_msb_chg    = (sh_kind == SH_ALSH) && (A[WIDTH-1] != A[WIDTH-2]);
    assign work_shift1  = shift_one(work_q, sh_kind_q);
    assign work_msb_chg = (sh_kind_q == SH_ALSH) && (work_q[WIDTH-1] != work_q[WIDTH-2]);

    // Single-cycle result; flags start from the stored value so untouched ones are preserved.
    always_comb begin
        res     = '0;
        flags_n = flags_q;
        case (kind)
            K_ADDS: begin
                res         = add_sum[WIDTH-1:0];
                flags_n[FC] = add_sum[WIDTH];
                flags_n[FF] = add_ovf;
            end
            K_ADDU: begin
                res         = add_sum[WIDTH-1:0];
                flags_n[FC] = add_sum[WIDTH];
                flags_n[FF] = add_sum[WIDTH];
            end
            K_SUB: begin
                res         = sub_diff[WIDTH-1:0];
                flags_n[FC] = sub_diff[WIDTH];
                flags_n[FF] = sub_ovf;
            end
            K_CMP: begin
                res         = '0;
                flags_n[FC] = 1'b0;
                flags_n[FF] = 1'b0;
                flags_n[FL] = sub_diff[WIDTH];
                flags_n[FN] = lt_signed;
                flags_n[FZ] = (A == B);
            end
            K_AND:   res = A & B;
            K_OR:    res = A | B;
            K_XOR:   res = A ^ B;
            K_NOT:   res = ~A;
            K_MOV:   res = B;
            K_SHIFT: begin
                res = (sh_amt == CNT_ZERO) ? A : a_shift1;
                if ((sh_amt != CNT_ZERO) && a_msb_chg) begin
                    flags_n[FF] = 1'b1;
                end
            end
            default: res = '0;
        endcase
    end

    // Shifts of two or more bits park here, one bit per edge, until the count runs out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            work_q      <= '0;
            cnt_q       <= '0;
            sh_kind_q   <= SH_LSH;
            msb_chg_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if ((kind == K_SHIFT) && (sh_amt > CNT_ONE)) begin
                            work_q    <= a_shift1;
                            cnt_q     <= sh_amt - CNT_ONE;
                            sh_kind_q <= sh_kind;
                            msb_chg_q <= a_msb_chg;
                            state_q   <= ST_SHIFT;
                        end else begin
                            s_q         <= res;
                            flags_q     <= flags_n;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_q    <= work_shift1;
                    cnt_q     <= cnt_q - CNT_ONE;
                    msb_chg_q <= msb_chg_q | work_msb_chg;
                    if (cnt_q == CNT_ONE) begin
                        s_q         <= work_shift1;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                        if (msb_chg_q | work_msb_chg) begin
                            flags_q[FF] <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign CLFZN     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16 and WIDTH=32 with hand-computed results.
module tb_alu_seq;

    logic        clk;
    logic        reset;

    logic        in_valid16, in_ready16, out_valid16;
    logic [3:0]  opcode16, opext16;
    logic [15:0] a16, b16, s16;
    logic [4:0]  flags16;

    logic        in_valid32, in_ready32, out_valid32;
    logic [3:0]  opcode32, opext32;
    logic [31:0] a32, b32, s32;
    logic [4:0]  flags32;

    int checks;
    int errors;

    alu_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .opcode(opcode16), .opext(opext16), .A(a16), .B(b16),
        .out_valid(out_valid16), .S(s16), .CLFZN(flags16)
    );

    alu_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .opcode(opcode32), .opext(opext32), .A(a32), .B(b32),
        .out_valid(out_valid32), .S(s32), .CLFZN(flags32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present an op, hold it until accepted, then count cycles until out_valid.
    task automatic applyStimulus(input bit wide, input logic [3:0] opc, input logic [3:0] ext,
                                 input logic [31:0] a, input logic [31:0] b, output int lat);
        int guard;
        @(negedge clk);
        if (wide) begin
            opcode32 = opc; opext32 = ext; a32 = a; b32 = b; in_valid32 = 1'b1;
        end else begin
            opcode16 = opc; opext16 = ext; a16 = a[15:0]; b16 = b[15:0]; in_valid16 = 1'b1;
        end
        guard = 0;
        while (!(wide ? in_ready32 : in_ready16) && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("accept_ready", 32'(wide ? in_ready32 : in_ready16), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        in_valid32 = 1'b0;
        lat = 1;
        while (!(wide ? out_valid32 : out_valid16) && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runOp(input string tag, input bit wide, input logic [3:0] opc,
                         input logic [3:0] ext, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_s, input logic [4:0] exp_f, input int exp_lat);
        int lat;
        applyStimulus(wide, opc, ext, a, b, lat);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_s"}, wide ? s32 : 32'(s16), exp_s);
        checkOutput({tag, "_flags"}, 32'(wide ? flags32 : flags16), 32'(exp_f));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int low;
        int pulses;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        in_valid16 = 1'b0; opcode16 = '0; opext16 = '0; a16 = '0; b16 = '0;
        in_valid32 = 1'b0; opcode32 = '0; opext32 = '0; a32 = '0; b32 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", 32'(in_ready16), 32'd1);
        checkOutput("rst_valid", 32'(out_valid16), 32'd0);
        checkOutput("rst_s", 32'(s16), 32'd0);
        checkOutput("rst_flags", 32'(flags16), 32'd0);

        runOp("add_ovf", 1'b0, 4'b0000, 4'b0101, 32'h7FFF, 32'h0001, 32'h8000, 5'h04, 1);
        @(negedge clk);
        checkOutput("valid_pulse", 32'(out_valid16), 32'd0);

        // ADD then ADDC on consecutive edges: the ADDC must see the fresh carry.
        @(negedge clk);
        opcode16 = 4'b0000; opext16 = 4'b0101; a16 = 16'hFFFF; b16 = 16'h0001; in_valid16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_add_valid", 32'(out_valid16), 32'd1);
        checkOutput("b2b_add_s", 32'(s16), 32'h0000);
        checkOutput("b2b_add_flags", 32'(flags16), 32'h10);
        opext16 = 4'b0111; a16 = 16'h0000; b16 = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        checkOutput("b2b_addc_valid", 32'(out_valid16), 32'd1);
        checkOutput("b2b_addc_s", 32'(s16), 32'h0001);
        checkOutput("b2b_addc_flags", 32'(flags16), 32'h00);

        runOp("cmp", 1'b0, 4'b0000, 4'b1011, 32'h8000, 32'h0001, 32'h0000, 5'h01, 1);
        runOp("and", 1'b0, 4'b0000, 4'b0001, 32'hF0F0, 32'h0FF0, 32'h00F0, 5'h01, 1);
        runOp("xor", 1'b0, 4'b0000, 4'b0011, 32'hFFFF, 32'h00FF, 32'hFF00, 5'h01, 1);
        runOp("not", 1'b0, 4'b1010, 4'b0011, 32'h00FF, 32'h0000, 32'hFF00, 5'h01, 1);
        runOp("cmpi_eq", 1'b0, 4'b1011, 4'b0110, 32'h1234, 32'h1234, 32'h0000, 5'h02, 1);
        runOp("cmpu", 1'b0, 4'b1010, 4'b0010, 32'h0001, 32'h8000, 32'h0000, 5'h08, 1);
        runOp("sub_ovf", 1'b0, 4'b0000, 4'b1001, 32'h8000, 32'h0001, 32'h7FFF, 5'h0C, 1);
        runOp("subi_borrow", 1'b0, 4'b1001, 4'b0000, 32'h0000, 32'h0001, 32'hFFFF, 5'h18, 1);
        runOp("addu", 1'b0, 4'b0000, 4'b0110, 32'hFFFF, 32'h0002, 32'h0001, 5'h1C, 1);
        runOp("addcui", 1'b0, 4'b1010, 4'b0110, 32'h0001, 32'h0001, 32'h0003, 5'h08, 1);

        // LSHI by 5 with a MOV held behind it for the whole shift.
        @(negedge clk);
        opcode16 = 4'b1000; opext16 = 4'b0000; a16 = 16'h0001; b16 = 16'h0005; in_valid16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        opcode16 = 4'b0000; opext16 = 4'b1101; a16 = 16'h1111; b16 = 16'hABCD;
        lat = 1;
        low = 0;
        while (!out_valid16 && lat < 64) begin
            if (!in_ready16) low++;
            @(negedge clk);
            lat++;
        end
        checkOutput("lshi_lat", 32'(lat), 32'd5);
        checkOutput("lshi_ready_low", 32'(low), 32'd4);
        checkOutput("lshi_s", 32'(s16), 32'h0020);
        checkOutput("lshi_ready_back", 32'(in_ready16), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        checkOutput("held_mov_valid", 32'(out_valid16), 32'd1);
        checkOutput("held_mov_s", 32'(s16), 32'hABCD);
        checkOutput("held_mov_flags", 32'(flags16), 32'h08);

        runOp("nop", 1'b0, 4'b0000, 4'b0000, 32'h5555, 32'h3333, 32'h0000, 5'h08, 1);
        runOp("arsh15", 1'b0, 4'b1010, 4'b0100, 32'h8000, 32'h000F, 32'hFFFF, 5'h08, 15);
        runOp("rsh3", 1'b0, 4'b0000, 4'b1110, 32'h8000, 32'h0003, 32'h1000, 5'h08, 3);
        runOp("rshi0", 1'b0, 4'b1110, 4'b0000, 32'h1234, 32'h0000, 32'h1234, 5'h08, 1);
        runOp("alsh3", 1'b0, 4'b1010, 4'b0001, 32'h2000, 32'h0003, 32'h0000, 5'h0C, 3);
        runOp("cmpi_clr", 1'b0, 4'b1011, 4'b0000, 32'h0005, 32'h0003, 32'h0000, 5'h00, 1);
        runOp("alsh1", 1'b0, 4'b1010, 4'b0001, 32'h4000, 32'h0001, 32'h8000, 5'h04, 1);
        runOp("lsh2", 1'b0, 4'b1000, 4'b0100, 32'h0001, 32'h0002, 32'h0004, 5'h04, 2);

        // Reset in the middle of a 10-bit shift abandons it.
        @(negedge clk);
        opcode16 = 4'b1000; opext16 = 4'b0000; a16 = 16'h0001; b16 = 16'h000A; in_valid16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("mid_shift_busy", 32'(in_ready16), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("shift_rst_ready", 32'(in_ready16), 32'd1);
        checkOutput("shift_rst_valid", 32'(out_valid16), 32'd0);
        checkOutput("shift_rst_s", 32'(s16), 32'd0);
        checkOutput("shift_rst_flags", 32'(flags16), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid16) pulses++;
        end
        checkOutput("shift_rst_no_pulse", 32'(pulses), 32'd0);

        runOp("w32_add_ovf", 1'b1, 4'b0000, 4'b0101, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'h04, 1);
        runOp("w32_sub_borrow", 1'b1, 4'b0000, 4'b1001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 5'h10, 1);
        runOp("w32_sub_ovf", 1'b1, 4'b0000, 4'b1001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'h04, 1);
        runOp("w32_lshi31", 1'b1, 4'b1000, 4'b0000, 32'h00000001, 32'h0000001F, 32'h80000000, 5'h04, 31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
